wb_hazard_ctrl: RTL and testbench
=================================

// Module: wb_hazard_ctrl
// PURPOSE
//  Parametrised writeback, register-file and hazard controller for the pipelined CPU core; sits after Execute.
//  Commits ALU/LOAD results to the register file, PC or overflow register and evaluates conditional writeback.
//  Detects read-after-write hazards against the Execute stage, issues stall/forward controls, and flushes on PC writes.
//  Adds over the previous core: multi-cycle flush, HALT opcode, write-through decode reads, optional forwarding.
// PARAMETERS
//  DATA_W       32  datapath width
//  PC_W         12  program counter width
//  NREGS        16  register indices, power of 2, >=4; index NREGS-2 = PC, NREGS-1 = overflow, rest general
//  FLUSH_CYCLES  1  cycles flush is held after a PC write, >=1
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active high
//  wb_valid       in   1          writeback-stage instruction present
//  wb_opc         in   5          opcode (0 = NOP)
//  wb_rc          in   RW         destination index, RW = $clog2(NREGS)
//  wb_cond        in   3          writeback condition
//  wb_cmp         in   1          update flags from wb_alu_status
//  wb_alu_result  in   DATA_W     ALU result
//  wb_alu_status  in   8          ALU status (bit0 zero, bit2 ge)
//  mem_rdata      in   DATA_W     load data
//  ex_valid/ex_imb  in  1/1       Execute-stage instruction valid / B is immediate
//  ex_ra/ex_rb    in   RW/RW      Execute-stage source indices
//  dec_ra/dec_rb  in   RW/RW      Decode read addresses
//  dec_a/dec_b    out  DATA_W     Decode read data (write-through)
//  pc             out  PC_W       instruction address
//  stall          out  1          hold Fetch/Decode/Execute
//  flush          out  1          pipeline clear
//  fwd_sel        out  2          01 = replace A, 10 = replace B, 00 = none
//  fwd_data       out  DATA_W     forwarded value
//  flags          out  8          registered ALU status
//  cpu_status     out  8          02 reset, 01 run, 03 flush, 04 halt
// BEHAVIOUR
//  Reset: pc=0, all regs/overflow=0, flags=0, stall=0, flush=1, fwd_sel=00, fwd_data=0, cpu_status=02, state RUN next cycle.
//  FSM RUN -> FLUSH (PC written) -> RUN after FLUSH_CYCLES; RUN -> HALT on opc 5'h1F; HALT exits only via rst.
//  Cond: 0 NEVER, 1 ALWAYS, 2 flags[0], 3 !flags[0], 4 flags[2], 5 !flags[2], 6-7 never; uses flags before this instruction.
//  commit = RUN & wb_valid & opc!=0 & opc!=STORE & (opc==LOAD | cond true); LOAD data = mem_rdata, else wb_alu_result.
//  wb_cmp & RUN & wb_valid: flags <= wb_alu_status on the next edge, regardless of cond.
//  Rc = PC: pc <= value[PC_W-1:0], no increment, flush=1 for FLUSH_CYCLES cycles, stall=0, fwd_sel=00.
//  Otherwise pc <= pc+1 (wraps at 2^PC_W) unless stall; pc holds in FLUSH and HALT.
//  hazard = commit & ex_valid & (ex_ra==Rc | (!ex_imb & ex_rb==Rc)); A match has priority over B.
//  The hazard is evaluated combinationally in the current cycle; the resulting stall, fwd_sel and fwd_data are registered
//  on the next edge and hold for one cycle.
//  Decode read of the index being committed this cycle returns the new value; reads of PC return zero-extended pc.
//  wb_valid is ignored in FLUSH and HALT. In HALT: no commits, stall=0, flush=0.
//  rst mid-flush or in HALT returns all state to reset values on the next edge.
// CONFIGURATION
//  WB_FWD_EN defined: a hazard from a non-LOAD instruction forwards (fwd_sel/fwd_data set, stall=0).
//  A LOAD hazard still stalls 1 cycle and forwards mem_rdata.
//  WB_FWD_EN undefined: every hazard stalls 1 cycle and sets fwd_sel/fwd_data to the committed value (previous-core behaviour).
// STRUCTURE
//  cpu_pkg: opcode localparams (NOP, LOAD, STORE, HALT=5'h1F), cond codes, state enum, cpu_status codes.
//  Sub-module cpu_regfile: NREGS-2 general registers, sync reset, 1 write port, 2 write-through read ports.
// TESTING
//  ADD Rc=3 cond ALWAYS result 0x55 -> dec_a(ra=3)=0x55 same cycle; r3=0x55 after edge; pc+1.
//  wb_cmp status 0x01 then cond ZERO write r4=7 -> r4=7; then cond NOTZERO write r4=9 -> r4 stays 7.
//  LOAD Rc=PC mem_rdata=0x123, FLUSH_CYCLES=2 -> pc=0x123, flush high 2 cycles, then cpu_status=01.
//  ALU Rc=5, ex_ra=5 -> WB_FWD_EN: fwd_sel=01, stall=0; without: stall=1 for 1 cycle, pc held.
//  LOAD Rc=6, ex_rb=6, ex_imb=0 -> stall=1 one cycle, fwd_sel=10, fwd_data=mem_rdata, both configs.
//  pc=0xFFF, no branch -> pc=0x000; opc 5'h1F -> cpu_status=04, pc frozen, rst -> cpu_status=02, pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes, condition codes, FSM states and status codes for the CPU writeback/hazard block.
package cpu_pkg;

   localparam logic [4:0] OPC_NOP   = 5'h00;
   localparam logic [4:0] OPC_LOAD  = 5'h01;
   localparam logic [4:0] OPC_STORE = 5'h02;
   localparam logic [4:0] OPC_ADD   = 5'h04;
   localparam logic [4:0] OPC_HALT  = 5'h1F;

   localparam logic [2:0] COND_NEVER   = 3'd0;
   localparam logic [2:0] COND_ALWAYS  = 3'd1;
   localparam logic [2:0] COND_ZERO    = 3'd2;
   localparam logic [2:0] COND_NOTZERO = 3'd3;
   localparam logic [2:0] COND_GE      = 3'd4;
   localparam logic [2:0] COND_LT      = 3'd5;

   localparam logic [7:0] STAT_RUN   = 8'h01;
   localparam logic [7:0] STAT_RESET = 8'h02;
   localparam logic [7:0] STAT_FLUSH = 8'h03;
   localparam logic [7:0] STAT_HALT  = 8'h04;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } cpu_state_e;

   function automatic logic cond_true(input logic [2:0] cond, input logic zero, input logic ge);
      logic r;
      case (cond)
         COND_NEVER:   r = 1'b0;
         COND_ALWAYS:  r = 1'b1;
         COND_ZERO:    r = zero;
         COND_NOTZERO: r = ~zero;
         COND_GE:      r = ge;
         COND_LT:      r = ~ge;
         default:      r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] status_of(input cpu_state_e st);
      logic [7:0] s;
      case (st)
         ST_RESET: s = STAT_RESET;
         ST_RUN:   s = STAT_RUN;
         ST_FLUSH: s = STAT_FLUSH;
         ST_HALT:  s = STAT_HALT;
         default:  s = STAT_RESET;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// General-purpose register file: NREGS-2 registers, one write port, two write-through read ports.
module cpu_regfile #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 16,
   parameter int RW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [RW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RW-1:0]     ra,
   input  logic [RW-1:0]     rb,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);
   localparam int NGEN = NREGS - 2;

   logic [DATA_W-1:0] regs_q [NGEN];
   logic [DATA_W-1:0] regs_d [NGEN];

   // Next register contents from the single write port
   always_comb begin
      for (int k = 0; k < NGEN; k++) begin
         regs_d[k] = (we && (waddr == RW'(k))) ? wdata : regs_q[k];
      end
   end

   // Register storage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NGEN; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads see the value being written this cycle; out-of-range indices read zero
   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      for (int k = 0; k < NGEN; k++) begin
         rdata_a = (ra == RW'(k)) ? regs_q[k] : rdata_a;
         rdata_b = (rb == RW'(k)) ? regs_q[k] : rdata_b;
      end
      rdata_a = (we && (ra == waddr)) ? wdata : rdata_a;
      rdata_b = (we && (rb == waddr)) ? wdata : rdata_b;
   end

endmodule

// File: rtl/wb_hazard_ctrl.sv
// Writeback, register-file and hazard controller sitting after Execute.
// Define WB_FWD_EN to forward non-LOAD hazards instead of stalling.
module wb_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int PC_W         = 12,
   parameter int NREGS        = 16,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   input  logic [4:0]               wb_opc,
   input  logic [$clog2(NREGS)-1:0] wb_rc,
   input  logic [2:0]               wb_cond,
   input  logic                     wb_cmp,
   input  logic [DATA_W-1:0]        wb_alu_result,
   input  logic [7:0]               wb_alu_status,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     ex_valid,
   input  logic                     ex_imb,
   input  logic [$clog2(NREGS)-1:0] ex_ra,
   input  logic [$clog2(NREGS)-1:0] ex_rb,
   input  logic [$clog2(NREGS)-1:0] dec_ra,
   input  logic [$clog2(NREGS)-1:0] dec_rb,
   output logic [DATA_W-1:0]        dec_a,
   output logic [DATA_W-1:0]        dec_b,
   output logic [PC_W-1:0]          pc,
   output logic                     stall,
   output logic                     flush,
   output logic [1:0]               fwd_sel,
   output logic [DATA_W-1:0]        fwd_data,
   output logic [7:0]               flags,
   output logic [7:0]               cpu_status
);
   localparam int RW = $clog2(NREGS);
   localparam logic [RW-1:0] PC_IDX  = RW'(NREGS - 2);
   localparam logic [RW-1:0] OVF_IDX = RW'(NREGS - 1);
   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   cpu_state_e        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] ovf_q, ovf_d;
   logic [7:0]        flags_q, flags_d;
   logic              stall_q, stall_d;
   logic              flush_q, flush_d;
   logic [1:0]        fwd_sel_q, fwd_sel_d;
   logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
   logic [7:0]        status_q, status_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              is_load, commit, pc_write, ovf_write, gpr_write;
   logic              hit_a, hit_b, hazard;
   logic [DATA_W-1:0] wb_value, rf_a, rf_b;

   // Commit decision and hazard detection for the instruction in writeback
   always_comb begin
      is_load   = (wb_opc == OPC_LOAD);
      wb_value  = is_load ? mem_rdata : wb_alu_result;
      commit    = (state_q == ST_RUN) && wb_valid && (wb_opc != OPC_NOP) &&
                  (wb_opc != OPC_STORE) && (wb_opc != OPC_HALT) &&
                  (is_load || cond_true(wb_cond, flags_q[0], flags_q[2]));
      pc_write  = commit && (wb_rc == PC_IDX);
      ovf_write = commit && (wb_rc == OVF_IDX);
      gpr_write = commit && !pc_write && !ovf_write;
      hit_a     = ex_valid && (ex_ra == wb_rc);
      hit_b     = ex_valid && !ex_imb && (ex_rb == wb_rc);
      hazard    = commit && !pc_write && (hit_a || hit_b);
   end

   cpu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .RW     (RW)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (gpr_write),
      .waddr   (wb_rc),
      .wdata   (wb_value),
      .ra      (dec_ra),
      .rb      (dec_rb),
      .rdata_a (rf_a),
      .rdata_b (rf_b)
   );

   // Decode read mux: PC and overflow live outside the general register file
   always_comb begin
      if (dec_ra == PC_IDX) begin
         dec_a = DATA_W'(pc_q);
      end else if (dec_ra == OVF_IDX) begin
         dec_a = ovf_write ? wb_value : ovf_q;
      end else begin
         dec_a = rf_a;
      end
      if (dec_rb == PC_IDX) begin
         dec_b = DATA_W'(pc_q);
      end else if (dec_rb == OVF_IDX) begin
         dec_b = ovf_write ? wb_value : ovf_q;
      end else begin
         dec_b = rf_b;
      end
   end

   // Next-state and registered-output logic of the RUN/FLUSH/HALT controller
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ovf_d      = ovf_q;
      flags_d    = flags_q;
      cnt_d      = cnt_q;
      stall_d    = 1'b0;
      fwd_sel_d  = 2'b00;
      fwd_data_d = '0;
      case (state_q)
         ST_RESET: state_d = ST_RUN;
         ST_RUN: begin
            flags_d = (wb_valid && wb_cmp) ? wb_alu_status : flags_q;
            ovf_d   = ovf_write ? wb_value : ovf_q;
            if (pc_write) begin
               pc_d = wb_value[PC_W-1:0];
            end else if (stall_q) begin
               pc_d = pc_q;
            end else begin
               pc_d = pc_q + 1'b1;
            end
            if (pc_write) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end else if (wb_valid && (wb_opc == OPC_HALT)) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
            if (hazard) begin
               fwd_sel_d  = hit_a ? 2'b01 : 2'b10;
               fwd_data_d = wb_value;
`ifdef WB_FWD_EN
               stall_d    = is_load;
`else
               stall_d    = 1'b1;
`endif
            end else begin
               fwd_sel_d  = 2'b00;
               fwd_data_d = '0;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RESET;
      endcase
      flush_d  = (state_d == ST_FLUSH) || (state_d == ST_RESET);
      status_d = status_of(state_d);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RESET;
         pc_q       <= '0;
         ovf_q      <= '0;
         flags_q    <= 8'h00;
         cnt_q      <= '0;
         stall_q    <= 1'b0;
         flush_q    <= 1'b1;
         fwd_sel_q  <= 2'b00;
         fwd_data_q <= '0;
         status_q   <= STAT_RESET;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ovf_q      <= ovf_d;
         flags_q    <= flags_d;
         cnt_q      <= cnt_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
         fwd_sel_q  <= fwd_sel_d;
         fwd_data_q <= fwd_data_d;
         status_q   <= status_d;
      end
   end

   assign pc         = pc_q;
   assign stall      = stall_q;
   assign flush      = flush_q;
   assign fwd_sel    = fwd_sel_q;
   assign fwd_data   = fwd_data_q;
   assign flags      = flags_q;
   assign cpu_status = status_q;

endmodule

// File: tb/tb_wb_hazard_ctrl.sv
// Self-checking bench for wb_hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_wb_hazard_ctrl;
   import cpu_pkg::*;

   localparam int DW  = 32;
   localparam int PW  = 12;
   localparam int NR  = 16;
   localparam int FC  = 2;
   localparam int PCI = NR - 2;
`ifdef WB_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_valid, wb_cmp, ex_valid, ex_imb;
   logic [4:0]    wb_opc;
   logic [3:0]    wb_rc, ex_ra, ex_rb, dec_ra, dec_rb;
   logic [2:0]    wb_cond;
   logic [DW-1:0] wb_alu_result, mem_rdata, dec_a, dec_b, fwd_data;
   logic [7:0]    wb_alu_status, flags, cpu_status;
   logic [PW-1:0] pc;
   logic          stall, flush;
   logic [1:0]    fwd_sel;

   always #5 clk = ~clk;

   wb_hazard_ctrl #(.DATA_W(DW), .PC_W(PW), .NREGS(NR), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_opc(wb_opc), .wb_rc(wb_rc),
      .wb_cond(wb_cond), .wb_cmp(wb_cmp), .wb_alu_result(wb_alu_result),
      .wb_alu_status(wb_alu_status), .mem_rdata(mem_rdata), .ex_valid(ex_valid),
      .ex_imb(ex_imb), .ex_ra(ex_ra), .ex_rb(ex_rb), .dec_ra(dec_ra), .dec_rb(dec_rb),
      .dec_a(dec_a), .dec_b(dec_b), .pc(pc), .stall(stall), .flush(flush),
      .fwd_sel(fwd_sel), .fwd_data(fwd_data), .flags(flags), .cpu_status(cpu_status)
   );

   // Behavioural model: architectural registers, pc, flags and pipeline mode
   logic [DW-1:0] m_regs [NR];
   logic [PW-1:0] m_pc;
   logic [7:0]    m_flags;
   bit            m_in_reset, m_halted;
   int            m_flush_left;
   logic          e_stall;
   logic [1:0]    e_sel;
   logic [DW-1:0] e_fd;

   int n_checks = 0;
   int n_errors = 0;
   logic [PW-1:0] p0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_running();
      return !m_in_reset && !m_halted && (m_flush_left == 0);
   endfunction

   function automatic logic [DW-1:0] m_val();
      return (wb_opc == OPC_LOAD) ? mem_rdata : wb_alu_result;
   endfunction

   function automatic bit m_commit();
      bit ok;
      case (wb_cond)
         3'd1:    ok = 1'b1;
         3'd2:    ok = m_flags[0];
         3'd3:    ok = !m_flags[0];
         3'd4:    ok = m_flags[2];
         3'd5:    ok = !m_flags[2];
         default: ok = 1'b0;
      endcase
      return m_running() && wb_valid && (wb_opc != OPC_NOP) && (wb_opc != OPC_STORE) &&
             (wb_opc != OPC_HALT) && ((wb_opc == OPC_LOAD) || ok);
   endfunction

   function automatic logic [DW-1:0] m_read(input logic [3:0] idx);
      if (idx == 4'(PCI)) return {{(DW-PW){1'b0}}, m_pc};
      if (m_commit() && (idx == wb_rc)) return m_val();
      return m_regs[idx];
   endfunction

   task automatic m_reset();
      for (int k = 0; k < NR; k++) m_regs[k] = '0;
      m_pc = '0; m_flags = 8'h00; m_in_reset = 1'b1; m_halted = 1'b0; m_flush_left = 0;
      e_stall = 1'b0; e_sel = 2'b00; e_fd = '0;
   endtask

   // Advance the model by one clock using the current inputs
   task automatic m_advance();
      bit            commit, hold;
      logic [DW-1:0] v;
      commit = m_commit();
      v      = m_val();
      hold   = e_stall;
      e_stall = 1'b0; e_sel = 2'b00; e_fd = '0;
      if (m_in_reset) begin
         m_in_reset = 1'b0;
      end else if (m_halted) begin
      end else if (m_flush_left > 0) begin
         m_flush_left--;
      end else begin
         if (wb_valid && wb_cmp) m_flags = wb_alu_status;
         if (commit && (wb_rc == 4'(PCI))) begin
            m_pc = v[PW-1:0];
            m_flush_left = FC;
         end else begin
            if (commit) begin
               m_regs[wb_rc] = v;
               if (ex_valid && ((ex_ra == wb_rc) || (!ex_imb && (ex_rb == wb_rc)))) begin
                  e_sel   = (ex_ra == wb_rc) ? 2'b01 : 2'b10;
                  e_fd    = v;
                  e_stall = FWD_EN ? (wb_opc == OPC_LOAD) : 1'b1;
               end
            end
            if (!hold) m_pc = m_pc + 12'd1;
            if (wb_valid && (wb_opc == OPC_HALT)) m_halted = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      logic [7:0] st;
      st = m_in_reset ? 8'h02 : m_halted ? 8'h04 : (m_flush_left > 0) ? 8'h03 : 8'h01;
      chk("pc", 32'(pc), 32'(m_pc));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("flush", 32'(flush), 32'(m_in_reset || (m_flush_left > 0)));
      chk("fwd_sel", 32'(fwd_sel), 32'(e_sel));
      chk("fwd_data", fwd_data, e_fd);
      chk("flags", 32'(flags), 32'(m_flags));
      chk("cpu_status", 32'(cpu_status), 32'(st));
   endtask

   task automatic set_idle();
      wb_valid = 1'b0; wb_opc = OPC_NOP; wb_rc = 4'd0; wb_cond = COND_NEVER; wb_cmp = 1'b0;
      wb_alu_result = '0; wb_alu_status = 8'h00; mem_rdata = '0;
      ex_valid = 1'b0; ex_imb = 1'b0; ex_ra = 4'd0; ex_rb = 4'd0; dec_ra = 4'd0; dec_rb = 4'd0;
   endtask

   task automatic wb(input logic [4:0] opc, input logic [3:0] rc, input logic [2:0] cond,
                     input logic [DW-1:0] res);
      set_idle();
      wb_valid = 1'b1; wb_opc = opc; wb_rc = rc; wb_cond = cond; wb_alu_result = res;
   endtask

   task automatic step();
      #1;
      chk("dec_a", dec_a, m_read(dec_ra));
      chk("dec_b", dec_b, m_read(dec_rb));
      m_advance();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle();
      @(posedge clk);
      #1;
      m_reset();
      check_outputs();
      rst = 1'b0;
   endtask

   task automatic rand_inputs();
      int r;
      wb_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 2)       wb_opc = OPC_HALT;
      else if (r < 27) wb_opc = OPC_LOAD;
      else if (r < 35) wb_opc = OPC_STORE;
      else if (r < 40) wb_opc = OPC_NOP;
      else             wb_opc = 5'($urandom_range(3, 30));
      wb_rc         = 4'($urandom_range(0, 15));
      wb_cond       = 3'($urandom_range(0, 7));
      wb_cmp        = 1'($urandom_range(0, 1));
      wb_alu_status = 8'($urandom);
      wb_alu_result = $urandom;
      mem_rdata     = $urandom;
      ex_valid      = 1'($urandom_range(0, 1));
      ex_imb        = 1'($urandom_range(0, 1));
      ex_ra  = ($urandom_range(0, 2) == 0) ? wb_rc : 4'($urandom_range(0, 15));
      ex_rb  = ($urandom_range(0, 2) == 0) ? wb_rc : 4'($urandom_range(0, 15));
      dec_ra = ($urandom_range(0, 2) == 0) ? wb_rc : 4'($urandom_range(0, 15));
      dec_rb = ($urandom_range(0, 2) == 0) ? wb_rc : 4'($urandom_range(0, 15));
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      #3;
      do_reset();
      set_idle();
      step();
      chk("run_status", 32'(cpu_status), 32'(STAT_RUN));

      // ALU write to r3 with same-cycle write-through read
      wb(OPC_ADD, 4'd3, COND_ALWAYS, 32'h55);
      dec_ra = 4'd3;
      #1;
      chk("wt_r3", dec_a, 32'h55);
      step();
      set_idle();
      dec_ra = 4'd3;
      #1;
      chk("r3", dec_a, 32'h55);
      chk("pc_inc", 32'(pc), 32'h1);

      // Conditional writeback using flags from an earlier compare
      wb(OPC_ADD, 4'd0, COND_NEVER, 32'h0);
      wb_cmp = 1'b1; wb_alu_status = 8'h01;
      step();
      wb(OPC_ADD, 4'd4, COND_ZERO, 32'h7);
      step();
      wb(OPC_ADD, 4'd4, COND_NOTZERO, 32'h9);
      step();
      set_idle();
      dec_rb = 4'd4;
      #1;
      chk("r4_cond", dec_b, 32'h7);

      // LOAD into PC: jump and two flush cycles
      wb(OPC_LOAD, 4'(PCI), COND_NEVER, 32'h0);
      mem_rdata = 32'h123;
      step();
      chk("jump_pc", 32'(pc), 32'h123);
      set_idle();
      step();
      chk("flush2", 32'(flush), 32'h1);
      step();
      chk("flush_end", 32'(flush), 32'h0);
      chk("flush_status", 32'(cpu_status), 32'(STAT_RUN));

      // ALU hazard on A
      wb(OPC_ADD, 4'd5, COND_ALWAYS, 32'hAA);
      ex_valid = 1'b1; ex_ra = 4'd5; ex_rb = 4'd0; ex_imb = 1'b1;
      step();
      chk("alu_fwd_sel", 32'(fwd_sel), 32'h1);
      chk("alu_stall", 32'(stall), FWD_EN ? 32'h0 : 32'h1);
      p0 = pc;
      set_idle();
      step();
      chk("alu_pc", 32'(pc), FWD_EN ? 32'(p0 + 12'd1) : 32'(p0));

      // LOAD hazard on B stalls in both builds
      wb(OPC_LOAD, 4'd6, COND_NEVER, 32'h0);
      mem_rdata = 32'hBEEF0006;
      ex_valid = 1'b1; ex_ra = 4'd1; ex_rb = 4'd6; ex_imb = 1'b0;
      step();
      chk("ld_stall", 32'(stall), 32'h1);
      chk("ld_sel", 32'(fwd_sel), 32'h2);
      chk("ld_data", fwd_data, 32'hBEEF0006);
      set_idle();
      step();
      chk("ld_stall_drop", 32'(stall), 32'h0);

      // PC wrap at 0xFFF
      wb(OPC_ADD, 4'(PCI), COND_ALWAYS, 32'hFFF);
      step();
      set_idle();
      step();
      step();
      chk("pc_fff", 32'(pc), 32'hFFF);
      step();
      chk("pc_wrap", 32'(pc), 32'h0);

      // Random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         if (($urandom_range(0, 199) == 0) || (m_halted && ($urandom_range(0, 7) == 0))) begin
            do_reset();
         end
         rand_inputs();
         step();
      end

      // HALT freezes the core until reset
      do_reset();
      set_idle();
      step();
      wb(OPC_HALT, 4'd0, COND_ALWAYS, 32'h0);
      step();
      chk("halt_status", 32'(cpu_status), 32'(STAT_HALT));
      p0 = pc;
      wb(OPC_ADD, 4'd3, COND_ALWAYS, 32'h1);
      repeat (3) step();
      chk("halt_pc", 32'(pc), 32'(p0));
      chk("halt_flush", 32'(flush), 32'h0);
      do_reset();
      chk("rst_status", 32'(cpu_status), 32'(STAT_RESET));
      chk("rst_pc", 32'(pc), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
